// File: rtl/freq_meas_gen_if.sv
// Control and result read port of the freq_meas_gen frequency counter.
// master: display/control logic side; slave: the counter core.
interface freq_meas_gen_if #(
    parameter int unsigned DIGITS = 8
) ();
    localparam int unsigned SelW = $clog2(DIGITS);

    logic [1:0]      gate_sel;
    logic            hold;
    logic [SelW-1:0] digit_sel;
    logic [3:0]      digit_bcd;
    logic            result_valid;
    logic            overflow;
    logic [1:0]      gate_exp;
    logic            gate_active;

    modport master (
        output gate_sel, hold, digit_sel,
        input  digit_bcd, result_valid, overflow, gate_exp, gate_active
    );

    modport slave (
        input  gate_sel, hold, digit_sel,
        output digit_bcd, result_valid, overflow, gate_exp, gate_active
    );
endinterface

// File: rtl/freq_meas_gen.sv
// Gated BCD frequency counter with back-to-back gates and a blanked result register.
// Optional multiplexed 7-segment scanner enabled by defining FREQ_DISPLAY_SCAN_EN.
module freq_meas_gen #(
    parameter int unsigned CLK_HZ      = 10_000_000,
    parameter int unsigned DIGITS      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sig_in,
    freq_meas_gen_if.slave    bus,
    output logic [7:0]        seg_n,
    output logic [DIGITS-1:0] dig_n
);
    localparam int unsigned PrescMax = CLK_HZ / 100;
    localparam int unsigned PrescW   = $clog2(PrescMax);

    typedef logic [DIGITS-1:0][3:0] bcd_t;
    typedef enum logic {StIdle, StCount} state_e;

    state_e                state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                  sync_last_q, edge_q;
    logic [PrescW-1:0]     presc_q, presc_d;
    logic [9:0]            tick_cnt_q, tick_cnt_d, gate_len_m1;
    logic [1:0]            gate_cur_q, gate_cur_d, gate_exp_q;
    bcd_t                  cnt_q, cnt_d, cnt_next, res_q;
    logic                  ovf_q, ovf_d, ovf_set, res_ovf_q, valid_q;
    logic                  tick, gate_start, gate_end, restart, latch, all_nines;

    function automatic bcd_t bcd_inc(input bcd_t v);
        logic carry;
        carry   = 1'b1;
        bcd_inc = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[i] == 4'd9) begin
                    bcd_inc[i] = 4'd0;
                end else begin
                    bcd_inc[i] = v[i] + 4'd1;
                    carry      = 1'b0;
                end
            end
        end
    endfunction

    // Zero digits above the most significant non-zero digit read as 4'hF.
    function automatic bcd_t blank_lz(input bcd_t v);
        logic seen;
        seen     = 1'b0;
        blank_lz = v;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (v[i] != 4'd0) seen = 1'b1;
            if (!seen) blank_lz[i] = 4'hF;
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            sync_last_q <= 1'b0;
            edge_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sync_last_q <= sync_q[SYNC_STAGES-1];
            edge_q      <= sync_q[SYNC_STAGES-1] & ~sync_last_q;
        end
    end

    assign tick    = (presc_q == PrescW'(PrescMax - 1));
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    always_comb begin
        gate_len_m1 = 10'd0;
        unique case (gate_cur_q)
            2'd0: gate_len_m1 = 10'd0;
            2'd1: gate_len_m1 = 10'd9;
            2'd2: gate_len_m1 = 10'd99;
            2'd3: gate_len_m1 = 10'd999;
        endcase
    end

    assign gate_start = (state_q == StIdle) && tick;
    assign gate_end   = (state_q == StCount) && tick && (tick_cnt_q == gate_len_m1);
    assign restart    = (state_q == StCount) && !gate_end && (bus.gate_sel != gate_cur_q);
    assign latch      = gate_end && !bus.hold;

    always_comb begin
        all_nines = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q[i] != 4'd9) all_nines = 1'b0;
        end
    end

    // Counter saturates at all 9s; the edge that would wrap it flags overflow instead.
    assign ovf_set  = edge_q && all_nines;
    assign cnt_next = (edge_q && !all_nines) ? bcd_inc(cnt_q) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (tick) state_d = StCount;
            StCount: if (restart) state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.gate_active = (state_q == StCount);
    end

    always_comb begin
        cnt_d      = cnt_q;
        tick_cnt_d = tick_cnt_q;
        gate_cur_d = gate_cur_q;
        ovf_d      = ovf_q;
        if (gate_start || gate_end) begin
            cnt_d      = '0;
            tick_cnt_d = '0;
            gate_cur_d = bus.gate_sel;
            ovf_d      = 1'b0;
        end else if (restart) begin
            cnt_d      = '0;
            tick_cnt_d = '0;
            ovf_d      = 1'b0;
        end else if (state_q == StCount) begin
            cnt_d = cnt_next;
            ovf_d = ovf_q | ovf_set;
            if (tick) tick_cnt_d = tick_cnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            tick_cnt_q <= '0;
            gate_cur_q <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            res_q      <= {DIGITS{4'hF}};
            res_ovf_q  <= 1'b0;
            gate_exp_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            tick_cnt_q <= tick_cnt_d;
            gate_cur_q <= gate_cur_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            valid_q    <= latch;
            if (latch) begin
                res_q      <= blank_lz(cnt_next);
                res_ovf_q  <= ovf_q | ovf_set;
                gate_exp_q <= gate_cur_q;
            end
        end
    end

    always_comb begin
        bus.digit_bcd = 4'hF;
        if (32'(bus.digit_sel) < DIGITS) bus.digit_bcd = res_q[bus.digit_sel];
    end

    assign bus.result_valid = valid_q;
    assign bus.overflow     = res_ovf_q;
    assign bus.gate_exp     = gate_exp_q;

`ifdef FREQ_DISPLAY_SCAN_EN
    localparam int unsigned DwellClk = (CLK_HZ >= 2000) ? CLK_HZ / 1000 : 2;
    localparam int unsigned BlankClk = CLK_HZ / 100000;
    localparam int unsigned DwellW   = $clog2(DwellClk);
    localparam int unsigned ScanW    = $clog2(DIGITS);

    logic [DwellW-1:0] dwell_q;
    logic [ScanW-1:0]  scan_q, scan_p_q;
    logic              blank_p_q, dwell_blank, dp_on;
    logic [7:0]        seg_q;
    logic [DIGITS-1:0] dig_q, dig_en;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'h3F;
            4'd1: seg7 = 7'h06;
            4'd2: seg7 = 7'h5B;
            4'd3: seg7 = 7'h4F;
            4'd4: seg7 = 7'h66;
            4'd5: seg7 = 7'h6D;
            4'd6: seg7 = 7'h7D;
            4'd7: seg7 = 7'h07;
            4'd8: seg7 = 7'h7F;
            4'd9: seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    always_comb begin
        dwell_blank = (32'(dwell_q) < BlankClk) || (32'(dwell_q) >= DwellClk - BlankClk);
        dp_on = ((gate_exp_q != 2'd3) && (32'(scan_q) + 32'(gate_exp_q) == 32'd2)) ||
                ((scan_q == '0) && res_ovf_q);
        dig_en = '0;
        dig_en[scan_p_q] = 1'b1;
    end

    // Segments lead the digit enable by one clock so the anode never sees stale segments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q   <= '0;
            scan_q    <= ScanW'(DIGITS - 1);
            scan_p_q  <= '0;
            blank_p_q <= 1'b1;
            seg_q     <= 8'hFF;
            dig_q     <= '1;
        end else begin
            if (dwell_q == DwellW'(DwellClk - 1)) begin
                dwell_q <= '0;
                scan_q  <= (scan_q == '0) ? ScanW'(DIGITS - 1) : scan_q - 1'b1;
            end else begin
                dwell_q <= dwell_q + 1'b1;
            end
            seg_q     <= {~dp_on, ~seg7(res_q[scan_q])};
            scan_p_q  <= scan_q;
            blank_p_q <= dwell_blank;
            dig_q     <= blank_p_q ? '1 : ~dig_en;
        end
    end

    assign seg_n = seg_q;
    assign dig_n = dig_q;
`else
    assign seg_n = 8'hFF;
    assign dig_n = '1;
`endif
endmodule
